uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

UART receive path: recovers 8N1-style frames from the asynchronous serial line using a single-cycle oversampling strike from the baud rate generator, and presents each byte on a valid/ready handshake. Sits between the board-level RX pin and the byte consumer (FIFO or controller). It is the receiving end of the link whose timing is produced by the baud rate generator.

## Interface
- DATA_BITS, 8: data bits per frame, LSB first; legal 5..9.
- OVERSAMPLE, 16: ticks per bit period; even, ≥ 8.

- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- i_Rx_clkTick  input  1  one-clk-wide strobe at BAUD_RATE*OVERSAMPLE; all bit timing advances only on cycles where it is high.
- i_Rx_serial  input  1  asynchronous serial line; idle high.
- o_Rx_data  output  DATA_BITS  last accepted byte.
- o_Rx_valid  output  1  o_Rx_data holds an unconsumed byte.
- i_Rx_ready  input  1  consumer accepts the byte when high with o_Rx_valid.
- o_Rx_frameErr  output  1  one-clk pulse: stop bit sampled low.
- o_Rx_parityErr  output  1  one-clk pulse: parity mismatch (constant 0 without the macro).
- o_Rx_overrun  output  1  one-clk pulse: new byte overwrote an unconsumed byte.

## Operation
- i_Rx_serial passes through a 2-flop synchronizer (both flops reset to 1); the FSM sees only the synchronized bit.
- States: IDLE, START, DATA, PARITY (macro only), STOP. Tick counter is $clog2(OVERSAMPLE) bits wide; bit counter is $clog2(DATA_BITS+1) bits wide.
- IDLE: on a tick with sync bit 0 -> START, tick counter = 0.
- START: count ticks; at count OVERSAMPLE/2-1 (mid start bit): bit 0 -> DATA, counter = 0; bit 1 -> IDLE (glitch rejected, no flag).
- DATA: at count OVERSAMPLE-1 (mid bit), shift the sampled bit into the MSB of the shift register (LSB-first), clear counter, increment bit count; after DATA_BITS bits -> PARITY or STOP.
- PARITY: sample at count OVERSAMPLE-1, check even parity over data+parity bit -> STOP.
- STOP: sample at count OVERSAMPLE-1; -> IDLE. Bit 1: commit byte to o_Rx_data, set o_Rx_valid. Bit 0: pulse o_Rx_frameErr, byte discarded, valid unchanged.
- Parity error: byte still committed; o_Rx_parityErr pulses in the same cycle as commit.
- Handshake: o_Rx_valid falls the cycle after o_Rx_valid & i_Rx_ready. o_Rx_data stable while valid is high, except on overrun.
- Commit while valid high and i_Rx_ready low: data overwritten, valid stays 1, o_Rx_overrun pulses.
- Commit in the same cycle as a handshake: new data loaded, valid stays 1, no overrun.
- Ticks are ignored in no state except as described; non-tick cycles hold all state.

## Timing
- Reset (reset_n low at a clk edge): state IDLE, counters 0, o_Rx_data 0, o_Rx_valid 0, all error pulses 0, synchronizer 1. Reset mid-frame aborts the frame with no flags.
- Input-to-FSM latency: 2 clk (synchronizer).
- Commit outputs (valid/data/error pulses) are registered: they update on the clk edge following the tick that samples the stop bit.
- Return to IDLE occurs at mid-stop bit, so a start bit following immediately after the stop bit is detected.
- Error/overrun pulses are exactly one clk wide.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present; frame = start + DATA_BITS + even parity + stop; o_Rx_parityErr driven.
- Undefined: no PARITY state; frame = start + DATA_BITS + stop; o_Rx_parityErr tied 0.

## Test plan
- OVERSAMPLE=16, tick every 4 clk, frame 0xA5 with stop 1, ready held 1 -> o_Rx_data=0xA5, o_Rx_valid high one clk, no error pulses.
- Line low for 4 ticks then high -> FSM returns to IDLE, o_Rx_valid stays 0, no flags.
- Frame 0x3C with stop bit 0 -> o_Rx_frameErr one-clk pulse, o_Rx_valid 0, o_Rx_data unchanged.
- Frames 0x11 then 0x22 back-to-back, ready 0 -> o_Rx_data=0x22, o_Rx_valid 1, o_Rx_overrun one pulse; ready 1 for one clk -> valid 0 next cycle.
- Macro defined: byte 0x01 with parity bit 0 -> data 0x01 committed with o_Rx_parityErr pulse; parity bit 1 -> no pulse.
- reset_n low during DATA bit 4, then frame 0x5A -> only 0x5A delivered, no flags.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N1-style frame recovery from an oversampling tick, valid/ready byte output.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Rx_clkTick,
  input  logic                 i_Rx_serial,
  output logic [DATA_BITS-1:0] o_Rx_data,
  output logic                 o_Rx_valid,
  input  logic                 i_Rx_ready,
  output logic                 o_Rx_frameErr,
  output logic                 o_Rx_parityErr,
  output logic                 o_Rx_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_CNT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sync_meta;
  logic                 rx_bit;

`ifdef UART_RX_PARITY_EN
  logic parity_bad;

  // Odd overall parity across data and received parity bit means an even-parity violation.
  function automatic logic parity_odd(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // Two-flop synchronizer for the asynchronous line, idle-high after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      rx_bit    <= 1'b1;
    end else begin
      sync_meta <= i_Rx_serial;
      rx_bit    <= sync_meta;
    end
  end

  // Frame FSM, output handshake and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      o_Rx_data     <= '0;
      o_Rx_valid    <= 1'b0;
      o_Rx_frameErr <= 1'b0;
      o_Rx_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad     <= 1'b0;
      o_Rx_parityErr <= 1'b0;
`endif
    end else begin
      o_Rx_frameErr <= 1'b0;
      o_Rx_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Rx_parityErr <= 1'b0;
`endif
      if (o_Rx_valid && i_Rx_ready) begin
        o_Rx_valid <= 1'b0;
      end

      if (i_Rx_clkTick) begin
        case (state)
          IDLE: begin
            if (!rx_bit) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_CNT) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              // A line already back high at mid start bit was a glitch.
              state    <= rx_bit ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              shreg    <= {rx_bit, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt   <= '0;
              parity_bad <= parity_odd(shreg, rx_bit);
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_bit) begin
                o_Rx_data    <= shreg;
                o_Rx_valid   <= 1'b1;
                o_Rx_overrun <= o_Rx_valid && !i_Rx_ready;
`ifdef UART_RX_PARITY_EN
                o_Rx_parityErr <= parity_bad;
`endif
              end else begin
                o_Rx_frameErr <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_Rx_parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed, table-driven bench for uart_rx_deserializer (OVERSAMPLE=16, tick every 4 clk).
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_tick = 1'b0;
  logic       rx_serial;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ferr, perr, ovr;
  logic [1:0] div = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
  int b_valid, b_ferr, b_perr, b_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_data;
    int         exp_valid_cycles;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[6];

  uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_Rx_clkTick(rx_tick), .i_Rx_serial(rx_serial),
    .o_Rx_data(rx_data), .o_Rx_valid(rx_valid), .i_Rx_ready(rx_ready),
    .o_Rx_frameErr(ferr), .o_Rx_parityErr(perr), .o_Rx_overrun(ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div     <= div + 2'd1;
    rx_tick <= (div == 2'd3);
  end

  always @(negedge clk) begin
    if (rx_valid) n_valid <= n_valid + 1;
    if (ferr)     n_ferr  <= n_ferr + 1;
    if (perr)     n_perr  <= n_perr + 1;
    if (ovr)      n_ovr   <= n_ovr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr;
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx_serial = 1'b1;
`endif
    send_bit(stop_b);
    rx_serial = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[4] = '{8'h81, 1'b0, 8'h00, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

    reset_n   = 1'b0;
    rx_serial = 1'b1;
    rx_ready  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_flags", {29'd0, ferr, perr, ovr}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) begin
      snap();
      send_frame(vecs[k].data, vecs[k].stop_bit, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("vec%0d_data", k), 32'(rx_data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d_valid_cycles", k), 32'(n_valid - b_valid), 32'(vecs[k].exp_valid_cycles));
      check($sformatf("vec%0d_frame_err", k), 32'(n_ferr - b_ferr), 32'(vecs[k].exp_ferr));
      check($sformatf("vec%0d_overrun", k), 32'(n_ovr - b_ovr), 32'h0);
      check($sformatf("vec%0d_parity_err", k), 32'(n_perr - b_perr), 32'h0);
      check($sformatf("vec%0d_valid_now", k), 32'(rx_valid), 32'h0);
    end

    // Short low pulse on the line must be rejected as a glitch.
    snap();
    rx_serial = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_valid", 32'(n_valid - b_valid), 32'h0);
    check("glitch_flags", 32'(n_ferr - b_ferr + n_ovr - b_ovr + n_perr - b_perr), 32'h0);
    check("glitch_data", 32'(rx_data), 32'h81);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("post_glitch_data", 32'(rx_data), 32'hC3);

    // Back-to-back frames with the consumer stalled.
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr_first_data", 32'(rx_data), 32'h11);
    check("ovr_first_valid", 32'(rx_valid), 32'h1);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_second_data", 32'(rx_data), 32'h22);
    check("ovr_second_valid", 32'(rx_valid), 32'h1);
    check("ovr_pulses", 32'(n_ovr - b_ovr), 32'h1);
    check("ovr_frame_err", 32'(n_ferr - b_ferr), 32'h0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("ovr_handshake_valid", 32'(rx_valid), 32'h0);
    check("ovr_handshake_data", 32'(rx_data), 32'h22);
    rx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("par_bad_data", 32'(rx_data), 32'h01);
    check("par_bad_pulse", 32'(n_perr - b_perr), 32'h1);
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("par_ok_pulse", 32'(n_perr - b_perr), 32'h0);
    check("par_ok_valid", 32'(n_valid - b_valid), 32'h1);
`endif

    // Reset in the middle of data bit 4 aborts the frame silently.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_serial = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_data", 32'(rx_data), 32'h0);
    check("midreset_valid", 32'(rx_valid), 32'h0);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("midreset_no_flags", 32'(n_ferr - b_ferr + n_ovr - b_ovr + n_perr - b_perr), 32'h0);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("after_reset_data", 32'(rx_data), 32'h5A);
    check("after_reset_valid", 32'(n_valid - b_valid), 32'h1);
    check("after_reset_flags", 32'(n_ferr - b_ferr + n_ovr - b_ovr + n_perr - b_perr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
